// File: rtl/bram_stream_reader.sv
// Read-side sequencer for a BRAM with a 1-cycle registered read: sweeps `count` words
// from `base` and presents them as a valid/ready stream with `last`.
module bram_stream_reader #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base,
  input  logic [ADDRESS_WIDTH:0]   count,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0]    mem_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last
);

  localparam int CW = ADDRESS_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] pointer, raddr_q;
  logic [CW-1:0]            issue_left, beat_left;
  logic                     inflight, inflight_last;
  logic                     accept, issue, pop;

  logic [DATA_WIDTH-1:0]    buf_data [2];
  logic [1:0]               buf_last;
  logic                     rd_ptr, wr_ptr;
  logic [1:0]               occupancy;

  assign out_valid = (occupancy != 2'd0);
  assign out_data  = buf_data[rd_ptr];
  assign out_last  = out_valid && buf_last[rd_ptr];
  assign pop       = out_valid && out_ready;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    issue      = 1'b0;
    raddr      = raddr_q;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = (count == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        // Issue only if the word it returns is guaranteed a free buffer slot on arrival.
        issue = (issue_left != '0) &&
                (({1'b0, occupancy} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop}));
        if (issue) raddr = pointer;
        if (pop && (beat_left == CW'(1))) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pointer       <= '0;
      raddr_q       <= '0;
      issue_left    <= '0;
      beat_left     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      occupancy     <= 2'd0;
    end else begin
      raddr_q       <= raddr;
      inflight      <= issue;
      inflight_last <= issue && (issue_left == CW'(1));
      if (accept) begin
        pointer    <= base;
        issue_left <= count;
        beat_left  <= count;
      end else begin
        if (issue) begin
          pointer    <= pointer + ADDRESS_WIDTH'(1);
          issue_left <= issue_left - CW'(1);
        end
        if (pop) beat_left <= beat_left - CW'(1);
      end
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      case ({inflight, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // NOTE: buffer storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (inflight) begin
      buf_data[wr_ptr] <= mem_dout;
      buf_last[wr_ptr] <= inflight_last;
    end
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side sequencer for the simple dual-port BRAM macro, which has a 1-cycle registered read, no read enable and read-first behaviour.
- On a `start` command it sweeps `count` consecutive words beginning at `base`.
- It hides the fixed 1-cycle read latency behind a 2-entry output buffer and presents the words as a valid/ready stream with a `last` marker.
- Used wherever a core dumps a memory region (scratchpad readout, instruction-memory readback) onto a streaming interface.

Parameters:
- DATA_WIDTH, 16, word width; must match the attached BRAM.
- ADDRESS_WIDTH, 11, BRAM address width; the memory depth is 1 << ADDRESS_WIDTH.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- base  input  ADDRESS_WIDTH  first word address; sampled with start.
- count  input  ADDRESS_WIDTH+1  number of words, 0 .. 1<<ADDRESS_WIDTH; sampled with start.
- busy  output  1  high while a command is in progress.
- done  output  1  one-cycle pulse when a command completes.
- raddr  output  ADDRESS_WIDTH  drives the BRAM read address.
- mem_dout  input  DATA_WIDTH  BRAM read data, valid 1 cycle after raddr.
- out_valid  output  1  stream data valid.
- out_ready  input  1  stream sink ready.
- out_data  output  DATA_WIDTH  stream word.
- out_last  output  1  high on the final word of a command.

Behaviour:
- Reset (synchronous) gives: state=IDLE; busy=0, done=0, out_valid=0, out_last=0; raddr=0; output buffer flushed; inflight=0.
- Reset asserted mid-command:
  - aborts the command with no done pulse;
  - the in-flight read result is discarded;
  - start is ignored in the reset cycle.
- States:
  - IDLE: start=1 latches base into the address pointer and count into both issue_left and beat_left.
    - count≠0 → RUN.
    - count=0 → DONE with no beats issued.
    - start in any non-IDLE state is ignored.
  - RUN: issues reads and emits beats. Goes to DONE in the cycle the final beat handshakes (out_valid && out_ready with beat_left=1).
  - DONE: done=1 for exactly this cycle, then IDLE. busy=0 in DONE.
- busy = (state==RUN).
- Read issue rule (RUN only), with pop = out_valid && out_ready:
  - A read is issued iff issue_left>0 and (occupancy + inflight − pop) ≤ 1, where occupancy = 0..2 buffered words.
  - On issue: raddr=pointer this cycle; pointer +1 modulo 1<<ADDRESS_WIDTH (wraps from max to 0); issue_left −1; inflight=1 next cycle.
  - raddr holds its value when not issuing. The BRAM reads every cycle, so non-issue reads are simply ignored.
- Capture: in the cycle after an issue, mem_dout is written into the buffer, tagged last if it was the final issue.
  - No buffer overflow is possible by construction; the verification bench asserts occupancy ≤ 2.
- Output:
  - out_valid = occupancy>0.
  - out_data and out_last come from the buffer head, FIFO order.
  - out_data, out_valid and out_last stay stable while out_valid && !out_ready.
- Latency: start sampled at cycle 0 → first raddr at cycle 1 → mem_dout at cycle 2 → out_valid first high at cycle 3.
- Throughput: with out_ready held at 1, one beat per cycle. A count=N command finishes its final handshake at cycle N+2, with done at cycle N+3.
- Backpressure: with out_ready=0, at most 2 words are buffered and issue stalls. Issue resumes so that sustained throughput returns to 1/cycle after ready rises.
- Read-first hazard: if the BRAM write port writes the same address in the issue cycle, the old contents are streamed. Coherence is the client's responsibility.
- count = 1<<ADDRESS_WIDTH: every word is read exactly once; the pointer ends back at base.

Test Plan:
- Basic sweep: memory[i]=i+0x100, base=5, count=4, out_ready=1 → out_data 0x105, 0x106, 0x107, 0x108 on cycles 3..6; out_last on 0x108; done pulse at cycle 7; busy high cycles 1..6.
- Address wrap: ADDRESS_WIDTH=4, base=14, count=4 → raddr sequence 14, 15, 0, 1; data order matches.
- Backpressure:
  - Stimulus: count=8, with out_ready toggling in the pattern 1, 0, 0, 1, 1, 0, …
  - Response: all 8 words delivered in order with none duplicated or lost; outputs stable while stalled; occupancy never exceeds 2.
- Zero length: start with count=0 → no out_valid; done=1 exactly at cycle 1; busy stays 0.
- Full depth: ADDRESS_WIDTH=4, count=16, base=3 → 16 beats covering every address once; last beat is addr 2 with out_last=1.
- Abort and ignore:
  - reset asserted at cycle 4 of a count=10 command → next cycle: out_valid=0, busy=0, no done pulse.
  - A new command afterwards runs normally.
  - start while busy is ignored: the beat count stays equal to the original count.
